// File: rtl/eee_spi_frame_slave_if.sv
// SPI conduit between an SPI master and eee_spi_frame_slave.
// The master modport drives clock, select and MOSI; the slave modport drives MISO and its enable.
interface eee_spi_frame_slave_if;
    logic spi_clk;
    logic spi_cs_n;
    logic spi_mosi;
    logic spi_miso;
    logic spi_miso_oe;

    modport master (output spi_clk, output spi_cs_n, output spi_mosi,
                    input spi_miso, input spi_miso_oe);
    modport slave  (input spi_clk, input spi_cs_n, input spi_mosi,
                    output spi_miso, output spi_miso_oe);
endinterface

// File: rtl/eee_spi_frame_slave.sv
// Oversampled SPI slave: snapshots N_WORDS outbound words per frame and deserialises indexed MOSI
// words. Define EEE_SPI_CRC8_EN to append a CRC-8 word after the data words of every frame.
module eee_spi_frame_slave #(
    parameter int unsigned WORD_W  = 16,
    parameter int unsigned N_WORDS = 4,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0,
    parameter int unsigned IDX_W   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    eee_spi_frame_slave_if.slave      spi,
    input  logic [N_WORDS*WORD_W-1:0] tx_data,
    output logic                      snap_pulse,
    output logic [WORD_W-1:0]         rx_data,
    output logic [IDX_W-1:0]          rx_index,
    output logic                      rx_valid,
    output logic                      frame_done,
    output logic                      abort_pulse,
    output logic                      busy
);
    localparam int unsigned BCNT_W = $clog2(WORD_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(WORD_W - 1);
`ifdef EEE_SPI_CRC8_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
`endif

    localparam logic [1:0] WAIT_IDLE = 2'd0;
    localparam logic [1:0] IDLE      = 2'd1;
    localparam logic [1:0] SHIFT     = 2'd2;

    logic [1:0]                state;
    logic                      sclk_s1, sclk_s2, sclk_d;
    logic                      cs_s1, cs_s2, cs_d;
    logic                      mosi_s1, mosi_s2;
    logic                      primed;
    logic [N_WORDS*WORD_W-1:0] frame_buf;
    logic [WORD_W-1:0]         rx_shift, rx_next, cur_word;
    logic [BCNT_W-1:0]         bit_cnt;
    logic [IDX_W-1:0]          word_idx;
    logic                      sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                      sample_edge, shift_edge, cs_fall, cs_rise;

    function automatic logic [WORD_W-1:0] pick_word(input logic [N_WORDS*WORD_W-1:0] fb,
                                                    input logic [IDX_W-1:0] idx);
        pick_word = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            if (idx == IDX_W'(k)) pick_word = fb[k*WORD_W +: WORD_W];
        end
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_d  <= 1'b1;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            primed  <= 1'b0;
        end else begin
            sclk_s1 <= spi.spi_clk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            cs_s1   <= spi.spi_cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= spi.spi_mosi;
            mosi_s2 <= mosi_s1;
            primed  <= 1'b1;
        end
    end

    assign sclk_rise   = sclk_s2 & ~sclk_d;
    assign sclk_fall   = ~sclk_s2 & sclk_d;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = ~cs_s2 & cs_d;
    assign cs_rise     = cs_s2 & ~cs_d;
    assign rx_next     = {rx_shift[WORD_W-2:0], mosi_s2};
    assign busy        = (state == SHIFT);

`ifdef EEE_SPI_CRC8_EN
    logic [7:0]        crc;
    logic              crc_run;
    logic [IDX_W-1:0]  crc_word;
    logic [BCNT_W-1:0] crc_bit;
    logic [WORD_W-1:0] crc_src;
    logic              crc_in;

    assign crc_src = pick_word(frame_buf, crc_word);
    assign crc_in  = crc_src[LAST_BIT - crc_bit];

    // One snapshot bit per clk, finishing long before the CRC word is shifted out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc      <= '0;
            crc_run  <= 1'b0;
            crc_word <= '0;
            crc_bit  <= '0;
        end else if (state == IDLE && cs_fall) begin
            crc      <= '0;
            crc_run  <= 1'b1;
            crc_word <= '0;
            crc_bit  <= '0;
        end else if (crc_run) begin
            crc <= {crc[6:0], 1'b0} ^ ({8{crc[7] ^ crc_in}} & 8'h07);
            if (crc_bit == LAST_BIT) begin
                crc_bit <= '0;
                if (crc_word == IDX_W'(N_WORDS - 1)) crc_run <= 1'b0;
                else crc_word <= crc_word + IDX_W'(1);
            end else begin
                crc_bit <= crc_bit + BCNT_W'(1);
            end
        end
    end

    always_comb begin
        cur_word = pick_word(frame_buf, word_idx);
        if (word_idx == IDX_W'(N_WORDS)) cur_word = WORD_W'(crc);
    end
`else
    always_comb begin
        cur_word = pick_word(frame_buf, word_idx);
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= WAIT_IDLE;
            frame_buf       <= '0;
            rx_shift        <= '0;
            bit_cnt         <= '0;
            word_idx        <= '0;
            rx_data         <= '0;
            rx_index        <= '0;
            rx_valid        <= 1'b0;
            snap_pulse      <= 1'b0;
            frame_done      <= 1'b0;
            abort_pulse     <= 1'b0;
            spi.spi_miso    <= 1'b0;
            spi.spi_miso_oe <= 1'b0;
        end else begin
            snap_pulse  <= 1'b0;
            rx_valid    <= 1'b0;
            frame_done  <= 1'b0;
            abort_pulse <= 1'b0;
            case (state)
                // primed keeps the reset value of the cs_n stages from counting as a real idle
                WAIT_IDLE: if (primed && cs_s1 && cs_s2) state <= IDLE;
                IDLE: begin
                    if (cs_fall) begin
                        state           <= SHIFT;
                        frame_buf       <= tx_data;
                        snap_pulse      <= 1'b1;
                        bit_cnt         <= '0;
                        word_idx        <= '0;
                        spi.spi_miso_oe <= 1'b1;
                        if (!CPHA) spi.spi_miso <= tx_data[WORD_W-1];
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state           <= IDLE;
                        spi.spi_miso    <= 1'b0;
                        spi.spi_miso_oe <= 1'b0;
                        if (bit_cnt == '0) frame_done <= 1'b1;
                        else abort_pulse <= 1'b1;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            rx_data  <= rx_next;
                            rx_index <= word_idx;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            word_idx <= (word_idx == LAST_IDX) ? '0 : word_idx + IDX_W'(1);
                        end else begin
                            bit_cnt <= bit_cnt + BCNT_W'(1);
                        end
                    end else if (shift_edge) begin
                        spi.spi_miso <= cur_word[LAST_BIT - bit_cnt];
                    end
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eee_spi_frame_slave.sv
// Directed bench for eee_spi_frame_slave: a mode-0 and a mode-3 instance driven by a bit-banged
// SPI master, with table vectors plus hand sequences for reset, snapshot stability and aborts.
module tb_eee_spi_frame_slave;
    localparam int H = 8;  // SPI half period in system clocks
`ifdef EEE_SPI_CRC8_EN
    localparam int NW_TOT = 5;
`else
    localparam int NW_TOT = 4;
`endif
    localparam logic [63:0] TXA = {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234};
    localparam logic [63:0] TXB = {16'hAAAA, 16'h5555, 16'h7FFE, 16'h8001};
    localparam logic [63:0] TX9 = {4{16'h9999}};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] tx_data = TXA;
    logic [1:0]  m_clk = 2'b10, m_cs = 2'b00, m_mosi = 2'b00;
    logic [1:0]  s_miso, s_oe, snap, rx_valid, frame_done, abort_p, busy;
    logic [15:0] rx_data [2];
    logic [3:0]  rx_index [2];

    int n_assert = 0;
    int n_fail = 0;
    int rx_cnt [2] = '{0, 0};
    int snap_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int abort_cnt [2] = '{0, 0};
    int oe_cnt [2] = '{0, 0};
    logic [15:0] rxd_log [2][64];
    logic [3:0]  rxi_log [2][64];

    eee_spi_frame_slave_if if0 ();
    eee_spi_frame_slave_if if1 ();

    assign if0.spi_clk  = m_clk[0];
    assign if0.spi_cs_n = m_cs[0];
    assign if0.spi_mosi = m_mosi[0];
    assign if1.spi_clk  = m_clk[1];
    assign if1.spi_cs_n = m_cs[1];
    assign if1.spi_mosi = m_mosi[1];
    assign s_miso = {if1.spi_miso, if0.spi_miso};
    assign s_oe   = {if1.spi_miso_oe, if0.spi_miso_oe};

    eee_spi_frame_slave #(.WORD_W(16), .N_WORDS(4), .CPOL(1'b0), .CPHA(1'b0), .IDX_W(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .spi(if0), .tx_data(tx_data), .snap_pulse(snap[0]),
        .rx_data(rx_data[0]), .rx_index(rx_index[0]), .rx_valid(rx_valid[0]),
        .frame_done(frame_done[0]), .abort_pulse(abort_p[0]), .busy(busy[0])
    );

    eee_spi_frame_slave #(.WORD_W(16), .N_WORDS(4), .CPOL(1'b1), .CPHA(1'b1), .IDX_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .spi(if1), .tx_data(tx_data), .snap_pulse(snap[1]),
        .rx_data(rx_data[1]), .rx_index(rx_index[1]), .rx_valid(rx_valid[1]),
        .frame_done(frame_done[1]), .abort_pulse(abort_p[1]), .busy(busy[1])
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rx_valid[d]) begin
                rxd_log[d][rx_cnt[d] % 64] = rx_data[d];
                rxi_log[d][rx_cnt[d] % 64] = rx_index[d];
                rx_cnt[d]++;
            end
            if (snap[d]) snap_cnt[d]++;
            if (frame_done[d]) done_cnt[d]++;
            if (abort_p[d]) abort_cnt[d]++;
            if (s_oe[d]) oe_cnt[d]++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bit-banged master; MISO captured just before each sample edge, newest bit in bit 0.
    task automatic xfer(input int d, input int nbits, input logic [15:0] mword,
                        output logic [127:0] got);
        logic cpha;
        cpha = (d == 1);
        got = '0;
        m_cs[d] = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            if (cpha) m_clk[d] = ~m_clk[d];
            m_mosi[d] = mword[15 - (i % 16)];
            wait_clk(H);
            got = {got[126:0], s_miso[d]};
            m_clk[d] = ~m_clk[d];
            wait_clk(H);
            if (!cpha) m_clk[d] = ~m_clk[d];
        end
        wait_clk(H);
        m_cs[d] = 1'b1;
    endtask

    function automatic logic [7:0] crc8_ref(input logic [63:0] tx);
        logic [7:0] c = 8'h00;
        for (int w = 0; w < 4; w++) begin
            for (int b = 15; b >= 0; b--) begin
                logic fb;
                fb = c[7] ^ tx[w*16 + b];
                c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    typedef struct {
        int           d;
        logic [63:0]  tx;
        logic [15:0]  mosi;
        int           nbits;
        logic [127:0] exp_miso;
        int           exp_rx;
        int           exp_done;
        int           exp_abort;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] got;
        int d, b_rx, b_done, b_abort, b_snap, n_rx;

        vecs[0] = '{0, TXA, 16'hA5A5, 64, 128'h1234ABCD0001FFFF, 4, 1, 0};
        vecs[1] = '{1, TXA, 16'hA5A5, 64, 128'h1234ABCD0001FFFF, 4, 1, 0};
        vecs[2] = '{0, TXA, 16'hA5A5, 7, 128'h09, 0, 0, 1};
`ifdef EEE_SPI_CRC8_EN
        vecs[3] = '{0, TXA, 16'h5A0F, 80, {48'h0, 64'h1234ABCD0001FFFF, 8'h00, crc8_ref(TXA)},
                    5, 1, 0};
`else
        vecs[3] = '{0, TXA, 16'h5A0F, 80, {48'h0, 64'h1234ABCD0001FFFF, 16'h1234}, 5, 1, 0};
`endif
        vecs[4] = '{1, TXB, 16'h3C0F, 7, 128'h40, 0, 0, 1};
        vecs[5] = '{1, TXB, 16'h3C0F, 64, 128'h80017FFE5555AAAA, 4, 1, 0};

        // Reset values, with cs_n held low on both links
        wait_clk(5);
        chk("reset miso", 128'(s_miso[0]), 0);
        chk("reset miso_oe", 128'(s_oe[0]), 0);
        chk("reset busy", 128'(busy[0]), 0);
        chk("reset rx_data", 128'(rx_data[0]), 0);
        chk("reset rx_index", 128'(rx_index[0]), 0);
        chk("reset rx_valid", 128'(rx_valid[0]), 0);
        chk("reset snap", 128'(snap[0]), 0);
        chk("reset frame_done", 128'(frame_done[0]), 0);
        chk("reset abort", 128'(abort_p[0]), 0);

        // Joining mid-frame must be refused until cs_n is seen high
        reset_n = 1'b1;
        wait_clk(4);
        for (int i = 0; i < 8; i++) begin
            m_clk = ~m_clk;
            wait_clk(H);
            m_clk = ~m_clk;
            wait_clk(H);
        end
        wait_clk(10);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midjoin rx d%0d", k), 128'(rx_cnt[k]), 0);
            chk($sformatf("midjoin oe d%0d", k), 128'(oe_cnt[k]), 0);
            chk($sformatf("midjoin snap d%0d", k), 128'(snap_cnt[k]), 0);
            chk($sformatf("midjoin busy d%0d", k), 128'(busy[k]), 0);
        end
        m_cs = 2'b11;
        wait_clk(10);

        for (int v = 0; v < 6; v++) begin
            d = vecs[v].d;
            tx_data = vecs[v].tx;
            b_rx = rx_cnt[d];
            b_done = done_cnt[d];
            b_abort = abort_cnt[d];
            b_snap = snap_cnt[d];
            xfer(d, vecs[v].nbits, vecs[v].mosi, got);
            wait_clk(12);
            n_rx = rx_cnt[d] - b_rx;
            chk($sformatf("v%0d miso", v), got, vecs[v].exp_miso);
            chk($sformatf("v%0d rx count", v), 128'(n_rx), 128'(vecs[v].exp_rx));
            for (int k = 0; k < vecs[v].exp_rx && k < n_rx; k++) begin
                chk($sformatf("v%0d rx_data %0d", v, k), 128'(rxd_log[d][(b_rx + k) % 64]),
                    128'(vecs[v].mosi));
                chk($sformatf("v%0d rx_index %0d", v, k), 128'(rxi_log[d][(b_rx + k) % 64]),
                    128'(k % NW_TOT));
            end
            chk($sformatf("v%0d frame_done", v), 128'(done_cnt[d] - b_done),
                128'(vecs[v].exp_done));
            chk($sformatf("v%0d abort", v), 128'(abort_cnt[d] - b_abort), 128'(vecs[v].exp_abort));
            chk($sformatf("v%0d snap", v), 128'(snap_cnt[d] - b_snap), 1);
            chk($sformatf("v%0d busy after", v), 128'(busy[d]), 0);
            chk($sformatf("v%0d oe after", v), 128'(s_oe[d]), 0);
        end

        // tx_data changes mid-frame: the running frame keeps its snapshot
        tx_data = TXA;
        b_snap = snap_cnt[0];
        fork
            xfer(0, 64, 16'h0F0F, got);
            begin
                wait_clk(300);
                tx_data = TX9;
            end
        join
        wait_clk(12);
        chk("snapshot hold miso", got, 128'h1234ABCD0001FFFF);
        chk("snapshot hold snap", 128'(snap_cnt[0] - b_snap), 1);
        b_snap = snap_cnt[0];
        xfer(0, 64, 16'h0F0F, got);
        wait_clk(12);
        chk("snapshot next miso", got, 128'h9999999999999999);
        chk("snapshot next snap", 128'(snap_cnt[0] - b_snap), 1);

        // Zero-word frame still counts as a clean frame
        b_done = done_cnt[0];
        b_abort = abort_cnt[0];
        xfer(0, 0, 16'h0000, got);
        wait_clk(12);
        chk("empty frame done", 128'(done_cnt[0] - b_done), 1);
        chk("empty frame abort", 128'(abort_cnt[0] - b_abort), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
